// File: rtl/ext_mem_loader_pkg.sv
// Shared state encoding and address strides for the external memory loader.
package ext_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DUMP_REQ,
    DUMP_WAIT,
    DUMP_OUT,
    DONE
  } state_t;

  localparam logic [63:0] IMEM_STRIDE = 64'd4;
  localparam logic [63:0] DMEM_STRIDE = 64'd8;

endpackage

// File: rtl/ext_mem_loader_if.sv
// Program stream, imem/dmem external ports and dump stream between loader and its environment.
interface ext_mem_loader_if;
  logic        prog_valid;
  logic        prog_ready;
  logic [31:0] prog_data;
  logic        prog_last;

  logic [63:0] addr_ext;
  logic        wen_ext;
  logic        ren_ext;
  logic [31:0] wdata_ext;

  logic [63:0] addr_ext_2;
  logic        wen_ext_2;
  logic        ren_ext_2;
  logic [63:0] wdata_ext_2;
  logic [63:0] rdata_ext_2;

  logic        dump_valid;
  logic        dump_ready;
  logic [63:0] dump_data;

  modport master (
    input  prog_valid, prog_data, prog_last, rdata_ext_2, dump_ready,
    output prog_ready, addr_ext, wen_ext, ren_ext, wdata_ext,
           addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2, dump_valid, dump_data
  );

  modport slave (
    output prog_valid, prog_data, prog_last, rdata_ext_2, dump_ready,
    input  prog_ready, addr_ext, wen_ext, ren_ext, wdata_ext,
           addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2, dump_valid, dump_data
  );
endinterface

// File: rtl/ext_mem_loader_down_counter.sv
// Loadable down-counter that saturates at zero; shared by the run window and the read-latency wait.
module loader_down_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/ext_mem_loader.sv
// Host-side loader: streams a program into imem, runs the CPU for a set cycle count, then dumps a dmem window.
module ext_mem_loader
  import ext_loader_pkg::*;
#(
  parameter int IMEM_WORDS = 512,
  parameter int RD_LAT     = 1,
  parameter int CYC_W      = 32
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             start,
  input  logic [CYC_W-1:0] run_cycles,
  input  logic [63:0]      dump_base,
  input  logic [15:0]      dump_count,
  ext_mem_loader_if.master bus,
  output logic             cpu_enable,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  localparam int IDX_W = $clog2(IMEM_WORDS + 1);

  state_t           state;
  logic [IDX_W-1:0] widx;
  logic [63:0]      imem_ptr;
  logic [63:0]      dmem_ptr;
  logic [15:0]      remaining;
  logic             wen_q;
  logic [63:0]      addr_q;
  logic [31:0]      wdata_q;
  logic             ren2_q;
  logic [63:0]      addr2_q;
  logic             prog_ready_q;
  logic             dump_valid_q;
  logic [63:0]      dump_data_q;
  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_zero;
  logic [CYC_W-1:0] cnt_val;

  // The counter holds run_cycles from start until RUN, then is reused for the read latency.
  always_comb begin
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = run_cycles;
    case (state)
      IDLE, DONE:     cnt_load = start;
      RUN, DUMP_WAIT: cnt_dec  = 1'b1;
      DUMP_REQ: begin
        cnt_load = (remaining != 16'd0);
        cnt_val  = CYC_W'(RD_LAT);
      end
      default: ;
    endcase
  end

  loader_down_counter #(.W(CYC_W)) u_cnt (
    .clk      (clk),
    .arst_n   (arst_n),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state        <= IDLE;
      widx         <= '0;
      imem_ptr     <= '0;
      dmem_ptr     <= '0;
      remaining    <= '0;
      wen_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      ren2_q       <= 1'b0;
      addr2_q      <= '0;
      prog_ready_q <= 1'b0;
      dump_valid_q <= 1'b0;
      dump_data_q  <= '0;
      cpu_enable   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      wen_q  <= 1'b0;
      ren2_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state        <= LOAD;
            prog_ready_q <= 1'b1;
            busy         <= 1'b1;
            done         <= 1'b0;
            overflow     <= 1'b0;
            widx         <= '0;
            imem_ptr     <= '0;
            dmem_ptr     <= dump_base;
            remaining    <= dump_count;
          end
        end
        LOAD: begin
          if (bus.prog_valid && prog_ready_q) begin
            if (widx < IDX_W'(IMEM_WORDS)) begin
              wen_q    <= 1'b1;
              addr_q   <= imem_ptr;
              wdata_q  <= bus.prog_data;
              imem_ptr <= imem_ptr + IMEM_STRIDE;
              widx     <= widx + IDX_W'(1);
            end else begin
              overflow <= 1'b1;
            end
            if (bus.prog_last) begin
              prog_ready_q <= 1'b0;
              state        <= RUN;
            end
          end
        end
        RUN: begin
          // First RUN cycle overlaps the final imem write, so enable starts one cycle later.
          if (cnt_zero) begin
            cpu_enable <= 1'b0;
            state      <= DUMP_REQ;
          end else begin
            cpu_enable <= 1'b1;
          end
        end
        DUMP_REQ: begin
          if (remaining == 16'd0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            ren2_q  <= 1'b1;
            addr2_q <= dmem_ptr;
            state   <= DUMP_WAIT;
          end
        end
        DUMP_WAIT: begin
          if (cnt_zero) begin
            dump_data_q  <= bus.rdata_ext_2;
            dump_valid_q <= 1'b1;
            state        <= DUMP_OUT;
          end
        end
        DUMP_OUT: begin
          if (bus.dump_ready) begin
            dump_valid_q <= 1'b0;
            dmem_ptr     <= dmem_ptr + DMEM_STRIDE;
            remaining    <= remaining - 16'd1;
            state        <= DUMP_REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.prog_ready  = prog_ready_q;
  assign bus.addr_ext    = addr_q;
  assign bus.wen_ext     = wen_q;
  assign bus.ren_ext     = 1'b0;
  assign bus.wdata_ext   = wdata_q;
  assign bus.addr_ext_2  = addr2_q;
  assign bus.wen_ext_2   = 1'b0;
  assign bus.ren_ext_2   = ren2_q;
  assign bus.wdata_ext_2 = '0;
  assign bus.dump_valid  = dump_valid_q;
  assign bus.dump_data   = dump_data_q;

endmodule

// File: tb/tb_ext_mem_loader.sv
// Directed bench for ext_mem_loader: queue-based model of imem writes, run window and dmem dump, checked every cycle.
module tb_ext_mem_loader;

  localparam int IMEM_W = 4;

  logic        clk;
  logic        arst_n;
  logic        start;
  logic [31:0] run_cycles;
  logic [63:0] dump_base;
  logic [15:0] dump_count;
  logic        cpu_enable;
  logic        busy;
  logic        done;
  logic        overflow;

  ext_mem_loader_if bus ();

  ext_mem_loader #(.IMEM_WORDS(IMEM_W), .RD_LAT(1), .CYC_W(32)) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .start      (start),
    .run_cycles (run_cycles),
    .dump_base  (dump_base),
    .dump_count (dump_count),
    .bus        (bus),
    .cpu_enable (cpu_enable),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow)
  );

  int total = 0;
  int bad   = 0;

  logic [63:0] dmem [64];
  logic [31:0] prog_words [8];

  logic [63:0] exp_wr_a[$];
  logic [31:0] exp_wr_d[$];
  logic [63:0] exp_rd[$];
  logic [63:0] exp_dump[$];
  logic [63:0] got_wr_a[$];
  logic [31:0] got_wr_d[$];
  logic [63:0] got_dump[$];
  int          en_cnt;
  int          en_runs;
  int          stall_left;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-outstanding dmem responder with one cycle of read latency.
  always @(posedge clk) begin
    if (bus.ren_ext_2) bus.rdata_ext_2 <= dmem[bus.addr_ext_2[8:3]];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic monitor();
    logic        prev_en;
    logic        prev_stall;
    logic [63:0] prev_data;
    logic        rd_out;
    prev_en = 0; prev_stall = 0; prev_data = '0; rd_out = 0;
    forever begin
      @(negedge clk);
      if (!arst_n) begin
        prev_en = 0; prev_stall = 0; rd_out = 0;
      end else begin
        chk("ren_ext_tied", bus.ren_ext, 0);
        chk("wen_ext_2_tied", bus.wen_ext_2, 0);
        chk("wdata_ext_2_tied", bus.wdata_ext_2, 0);
        if (bus.wen_ext) begin
          if (exp_wr_a.size() == 0) chk("wen_unexpected", bus.wen_ext, 0);
          else begin
            chk("imem_addr", bus.addr_ext, exp_wr_a.pop_front());
            chk("imem_data", bus.wdata_ext, exp_wr_d.pop_front());
            got_wr_a.push_back(bus.addr_ext);
            got_wr_d.push_back(bus.wdata_ext);
          end
        end
        if (cpu_enable) begin
          en_cnt++;
          if (!prev_en) en_runs++;
          chk("en_after_writes", 64'(exp_wr_a.size()), 0);
          chk("en_no_ren2", bus.ren_ext_2, 0);
        end
        if (bus.ren_ext_2) begin
          chk("ren2_single_outstanding", rd_out, 0);
          if (exp_rd.size() == 0) chk("ren2_unexpected", bus.ren_ext_2, 0);
          else chk("dmem_addr", bus.addr_ext_2, exp_rd.pop_front());
          rd_out = 1;
        end
        if (prev_stall) begin
          chk("dump_hold_valid", bus.dump_valid, 1);
          chk("dump_hold_data", bus.dump_data, prev_data);
          chk("dump_stall_no_ren2", bus.ren_ext_2, 0);
        end
        if (bus.dump_valid && bus.dump_ready) begin
          if (exp_dump.size() == 0) chk("dump_unexpected", bus.dump_valid, 0);
          else chk("dump_data", bus.dump_data, exp_dump.pop_front());
          got_dump.push_back(bus.dump_data);
          rd_out = 0;
        end
        prev_stall = bus.dump_valid && !bus.dump_ready;
        prev_data  = bus.dump_data;
        prev_en    = cpu_enable;
      end
    end
  endtask

  task automatic setup_model(input int n, input logic [63:0] base, input logic [15:0] cnt, input int stall);
    logic [63:0] a;
    exp_wr_a.delete(); exp_wr_d.delete(); exp_rd.delete(); exp_dump.delete();
    got_wr_a.delete(); got_wr_d.delete(); got_dump.delete();
    for (int i = 0; i < n; i++) begin
      if (i < IMEM_W) begin
        exp_wr_a.push_back(64'(i) * 64'd4);
        exp_wr_d.push_back(prog_words[i]);
      end
    end
    for (int k = 0; k < int'(cnt); k++) begin
      a = base + 64'(k) * 64'd8;
      exp_rd.push_back(a);
      exp_dump.push_back(dmem[a[8:3]]);
    end
    en_cnt = 0; en_runs = 0; stall_left = stall;
  endtask

  task automatic start_and_feed(input int n, input logic [31:0] rc, input logic [63:0] base, input logic [15:0] cnt);
    int w;
    run_cycles = rc; dump_base = base; dump_count = cnt; start = 1;
    @(posedge clk); #1;
    start = 0;
    for (int i = 0; i < n; i++) begin
      bus.prog_valid = 1;
      bus.prog_data  = prog_words[i];
      bus.prog_last  = (i == n - 1);
      w = 0;
      @(negedge clk);
      while (!bus.prog_ready && w < 50) begin
        @(negedge clk);
        w++;
      end
      chk("prog_ready_wait", bus.prog_ready, 1);
      @(posedge clk); #1;
    end
    bus.prog_valid = 0;
    bus.prog_last  = 0;
    chk("prog_ready_drop", bus.prog_ready, 0);
  endtask

  task automatic run_session(input int n, input logic [31:0] rc, input logic [63:0] base,
                             input logic [15:0] cnt, input int stall, input logic exp_ovf);
    int c;
    setup_model(n, base, cnt, stall);
    bus.dump_ready = 1;
    start_and_feed(n, rc, base, cnt);
    c = 0;
    while (!done && c < 3000) begin
      @(posedge clk); #1;
      if (bus.dump_valid && stall_left > 0) begin
        bus.dump_ready = 0;
        stall_left--;
      end else begin
        bus.dump_ready = 1;
      end
      c++;
    end
    chk("done_reached", done, 1);
    chk("done_after_last_dump", 64'(got_dump.size()), 64'(cnt));
    @(negedge clk);
    chk("en_cycles", 64'(en_cnt), 64'(rc));
    chk("en_contiguous", 64'(en_runs), (rc != 0) ? 64'd1 : 64'd0);
    chk("writes_left", 64'(exp_wr_a.size()), 0);
    chk("reads_left", 64'(exp_rd.size()), 0);
    chk("dumps_left", 64'(exp_dump.size()), 0);
    chk("overflow", overflow, exp_ovf);
    chk("busy_end", busy, 0);
    chk("en_end", cpu_enable, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    arst_n = 0; start = 0; run_cycles = '0; dump_base = '0; dump_count = '0;
    bus.prog_valid = 0; bus.prog_data = '0; bus.prog_last = 0; bus.dump_ready = 1;
    for (int i = 0; i < 64; i++) dmem[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
    dmem[8] = 64'h11; dmem[9] = 64'h22; dmem[10] = 64'h33;
    fork monitor(); join_none

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cpu_enable", cpu_enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_prog_ready", bus.prog_ready, 0);
    chk("rst_wen_ext", bus.wen_ext, 0);
    chk("rst_ren_ext_2", bus.ren_ext_2, 0);
    chk("rst_dump_valid", bus.dump_valid, 0);
    chk("rst_dump_data", bus.dump_data, 0);
    @(posedge clk); #1;
    arst_n = 1;
    repeat (2) @(posedge clk); #1;

    // 3-word program, 10 run cycles, dump three words with a 5-cycle sink stall.
    prog_words[0] = 32'h00500093; prog_words[1] = 32'h00a00113; prog_words[2] = 32'h002081b3;
    run_session(3, 32'd10, 64'h40, 16'd3, 5, 1'b0);
    chk("s1_wr2_addr", got_wr_a[2], 64'h8);
    chk("s1_wr0_data", 64'(got_wr_d[0]), 64'h00500093);
    chk("s1_dump0", got_dump[0], 64'h11);
    chk("s1_dump1", got_dump[1], 64'h22);
    chk("s1_dump2", got_dump[2], 64'h33);
    chk("s1_done", done, 1);

    // Restart from DONE: 6-word program into a 4-word imem, dump window wraps past 2^64.
    for (int i = 0; i < 6; i++) prog_words[i] = 32'h1000_0001 + 32'(i);
    run_session(6, 32'd3, 64'hFFFF_FFFF_FFFF_FFF8, 16'd2, 0, 1'b1);
    chk("s2_wr_count", 64'(got_wr_a.size()), 64'd4);
    chk("s2_last_addr", got_wr_a[3], 64'hC);
    chk("s2_dump0", got_dump[0], 64'hA5A5_0000_0000_003F);
    chk("s2_dump1", got_dump[1], 64'hA5A5_0000_0000_0000);

    // Abort mid-RUN with an asynchronous reset.
    prog_words[0] = 32'h00100073;
    setup_model(1, 64'h0, 16'd1, 0);
    start_and_feed(1, 32'd1000, 64'h0, 16'd1);
    c = 0;
    while (!cpu_enable && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    chk("abort_en_seen", cpu_enable, 1);
    repeat (3) @(posedge clk);
    #3 arst_n = 0;
    #1;
    chk("abort_en_drop", cpu_enable, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_prog_ready", bus.prog_ready, 0);
    setup_model(0, 64'h0, 16'd0, 0);
    @(posedge clk); #1;
    arst_n = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("abort_idle_busy", busy, 0);
    chk("abort_idle_en", cpu_enable, 0);

    // run_cycles=0 and dump_count=0: straight through to DONE, CPU never enabled.
    prog_words[0] = 32'hDEADBEEF;
    run_session(1, 32'd0, 64'h100, 16'd0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ext_mem_loader.md
Name: ext_mem_loader

Overview:
- Host-side initiator for the CPU's external memory ports; the counterpart to the CPU's responder-side addr_ext/wen_ext/ren_ext (imem) and addr_ext_2 (dmem) interfaces.
- Streams a program into instruction memory, holds the CPU enable for a programmed cycle count, then reads a window of data memory and streams it out.
- Sits in the testbench/SoC wrapper directly above cpu.

Parameters:
- IMEM_WORDS, 512, instruction memory capacity in 32-bit words.
- RD_LAT, 1, cycles from ren_ext_2 assertion to valid rdata_ext_2.
- CYC_W, 32, width of the run-cycle counter.

Ports:
- clk  in  1  main clock
- arst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begins a session when idle
- run_cycles  in  CYC_W  CPU enable duration, sampled at start
- dump_base  in  64  dmem byte address of first dump word, sampled at start
- dump_count  in  16  number of 64-bit words to dump, sampled at start
- prog_valid  in  1  program word valid
- prog_ready  out  1  loader accepts program word
- prog_data  in  32  instruction word
- prog_last  in  1  marks the final program word
- cpu_enable  out  1  drives cpu enable
- addr_ext  out  64  imem byte address
- wen_ext  out  1  imem write strobe
- ren_ext  out  1  imem read strobe; tied 0
- wdata_ext  out  32  imem write word
- addr_ext_2  out  64  dmem byte address
- wen_ext_2  out  1  dmem write strobe; tied 0
- ren_ext_2  out  1  dmem read strobe
- wdata_ext_2  out  64  tied 0
- rdata_ext_2  in  64  dmem read word
- dump_valid  out  1  dump word valid
- dump_ready  in  1  sink accepts dump word
- dump_data  out  64  dump word
- busy  out  1  high in any state except IDLE and DONE
- done  out  1  high in DONE
- overflow  out  1  sticky; program exceeded IMEM_WORDS

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. arst_n low at any point (including mid-session) aborts the session, drops cpu_enable immediately, and returns to IDLE.
- Port roles: clk and arst_n are the single clock and the asynchronous active-low reset.
- IDLE:
  - prog_ready=0.
  - On start, latch run_cycles, dump_base and dump_count; clear the word index and overflow; go to LOAD.
- LOAD:
  - prog_ready=1.
  - On a beat (prog_valid&prog_ready), in the next cycle drive wen_ext=1 for exactly one cycle, with addr_ext=4*index and wdata_ext=prog_data; then index++.
  - When index reaches IMEM_WORDS, further beats are accepted but not written (wen_ext=0) and overflow is set.
  - A beat with prog_last set moves to RUN after its write; a single-word program is legal.
- RUN:
  - cpu_enable=1 for exactly run_cycles consecutive cycles, using a down-counter loaded with run_cycles.
  - run_cycles=0 skips RUN; cpu_enable never asserts.
  - Then go to DUMP_REQ.
- DUMP_REQ:
  - If the remaining count is 0, go to DONE.
  - Otherwise drive ren_ext_2=1 for one cycle with addr_ext_2=dump_base+8*k, then go to DUMP_WAIT.
- DUMP_WAIT:
  - After RD_LAT cycles, capture rdata_ext_2 into the dump_data register and go to DUMP_OUT.
- DUMP_OUT:
  - dump_valid=1; dump_data holds stable until dump_ready.
  - On the handshake: k++, remaining--, then DUMP_REQ.
  - Only one read is outstanding at a time.
- DONE: done=1, and overflow holds its value. start returns to LOAD with freshly latched inputs.
- start outside IDLE/DONE is ignored.
- cpu_enable is 0 in every state except RUN, so the CPU never runs while the loader drives memory.
- Address arithmetic is modulo 2^64 and wraps silently.

Decomposition:
- Shared package ext_loader_pkg holds:
  - the state enum (IDLE, LOAD, RUN, DUMP_REQ, DUMP_WAIT, DUMP_OUT, DONE);
  - the constants IMEM_STRIDE=4 and DMEM_STRIDE=8.
- One sub-module, loader_down_counter: a loadable CYC_W down-counter with a zero flag, reused for the run cycles and the RD_LAT wait.

Test Plan:
- 3-word program (0x00500093, 0x00a00113, 0x002081b3, last on the third):
  - wen_ext pulses at addr 0, 4, 8 with those words;
  - prog_ready drops after the third beat.
- run_cycles=10: cpu_enable is high for exactly 10 cycles, contiguous, and only after the last imem write.
- dump_base=0x40, dump_count=3, dmem preloaded with 0x11, 0x22, 0x33 at 0x40, 0x48, 0x50:
  - dump_data sequence is 0x11, 0x22, 0x33;
  - done rises after the third handshake.
- dump_ready held low for 5 cycles during DUMP_OUT: dump_valid and dump_data stay stable; no extra ren_ext_2 pulses occur.
- IMEM_WORDS=4 with a 6-word program: writes occur only to addr 0-12, overflow=1, and the session still completes.
- Corner and abort cases:
  - run_cycles=0 with dump_count=0: goes from LOAD straight to DONE; cpu_enable never asserts.
  - arst_n pulsed low mid-RUN: cpu_enable drops immediately, state returns to IDLE, busy=0.
